conv_tile_scheduler: RTL and testbench

Sequencing controller between the tile-gathering input interface and the convolution PE. Waits for a complete multi-channel input tile, launches the PE on it, captures the flattened result, and hands it downstream over a valid/accept handshake. It then releases the input interface with `proc_finish` and walks a raster of tile positions until a frame completes.

---
 rtl/conv_sched_pkg.sv | 29 ++
 rtl/conv_tile_pos_counter.sv | 39 +++
 rtl/conv_tile_scheduler.sv | 150 +++++++++++++++
 tb/tb_conv_tile_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and parameter derivations for the convolution tile scheduler.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TILE,
    LAUNCH,
    COMPUTE,
    OUTPUT
  } sched_state_t;

  // Output tile edge; also the stride between neighbouring input tiles.
  function automatic int calc_s(input int tile_n, input int kernel_k);
    return tile_n - kernel_k + 1;
  endfunction

  function automatic int calc_tiles(input int img_len, input int tile_n, input int stride);
    return (img_len - tile_n) / stride + 1;
  endfunction

  function automatic int calc_out_bits(input int stride, input int kern_w, input int data_w);
    return stride * stride * (kern_w + data_w + 13);
  endfunction

  function automatic int cnt_w(input int count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/conv_tile_pos_counter.sv
// Raster row/col position counter over a TR x TC grid of tiles.
module conv_tile_pos_counter #(
  parameter int TC    = 4,
  parameter int TR    = 4,
  parameter int COL_W = 2,
  parameter int ROW_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == COL_W'(TC - 1));
  assign row_end = (row == ROW_W'(TR - 1));
  assign last    = col_end && row_end;

  // Advancing past the final tile wraps to the origin so a new frame starts clean.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Tile-level sequencer between the input tile gatherer and the convolution PE.
// Optional COMPUTE watchdog enabled by defining CONV_SCHED_WATCHDOG_EN.
module conv_tile_scheduler
  import conv_sched_pkg::*;
#(
  parameter int  INPUT_IMAGE_WIDTH  = 10,
  parameter int  INPUT_IMAGE_HEIGHT = 10,
  parameter int  INPUT_TILE_SIZE    = 4,
  parameter int  KERNEL_SIZE        = 3,
  parameter int  INPUT_DATA_WIDTH   = 8,
  parameter int  KERNEL_DATA_WIDTH  = 8,
  parameter int  WDT_CYCLES         = 1024,
  localparam int S        = calc_s(INPUT_TILE_SIZE, KERNEL_SIZE),
  localparam int TC       = calc_tiles(INPUT_IMAGE_WIDTH, INPUT_TILE_SIZE, S),
  localparam int TR       = calc_tiles(INPUT_IMAGE_HEIGHT, INPUT_TILE_SIZE, S),
  localparam int OUT_BITS = calc_out_bits(S, KERNEL_DATA_WIDTH, INPUT_DATA_WIDTH),
  localparam int COL_W    = cnt_w(TC),
  localparam int ROW_W    = cnt_w(TR)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_tile_ready,
  output logic                o_pe_valid,
  input  logic                i_pe_final_compute,
  input  logic                i_pe_final_flatten,
  input  logic [OUT_BITS-1:0] i_pe_data,
  output logic [OUT_BITS-1:0] o_tile_data,
  output logic                o_tile_valid,
  input  logic                i_tile_accept,
  output logic                o_proc_finish,
  output logic [ROW_W-1:0]    o_tile_row,
  output logic [COL_W-1:0]    o_tile_col,
  output logic                o_frame_done,
  output logic                o_busy,
  output logic                o_error
);

  sched_state_t state;
  logic         compute_seen;
  logic         flatten_ok;
  logic         pos_clear;
  logic         pos_advance;
  logic         pos_last;

  assign flatten_ok  = i_pe_final_flatten && (compute_seen || i_pe_final_compute);
  assign pos_clear   = (state == IDLE) && i_start;
  assign pos_advance = (state == OUTPUT) && i_tile_accept;

  conv_tile_pos_counter #(
    .TC    (TC),
    .TR    (TR),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_pos (
    .clk     (clk),
    .reset   (reset),
    .clear   (pos_clear),
    .advance (pos_advance),
    .row     (o_tile_row),
    .col     (o_tile_col),
    .last    (pos_last)
  );

`ifdef CONV_SCHED_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_cnt;
`else
  logic unused_wdt;
  assign unused_wdt = (WDT_CYCLES == 0);
  assign o_error    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      compute_seen  <= 1'b0;
      o_pe_valid    <= 1'b0;
      o_tile_valid  <= 1'b0;
      o_tile_data   <= '0;
      o_proc_finish <= 1'b0;
      o_frame_done  <= 1'b0;
      o_busy        <= 1'b0;
`ifdef CONV_SCHED_WATCHDOG_EN
      wdt_cnt       <= '0;
      o_error       <= 1'b0;
`endif
    end else begin
      o_pe_valid    <= 1'b0;
      o_proc_finish <= 1'b0;
      o_frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            o_busy <= 1'b1;
            state  <= WAIT_TILE;
`ifdef CONV_SCHED_WATCHDOG_EN
            o_error <= 1'b0;
`endif
          end
        end
        WAIT_TILE: begin
          if (i_tile_ready) state <= LAUNCH;
        end
        LAUNCH: begin
          o_pe_valid   <= 1'b1;
          compute_seen <= 1'b0;
          state        <= COMPUTE;
`ifdef CONV_SCHED_WATCHDOG_EN
          wdt_cnt      <= '0;
`endif
        end
        COMPUTE: begin
          if (i_pe_final_compute) compute_seen <= 1'b1;
          // A flatten strobe only counts once the PE has reported compute completion.
          if (flatten_ok) begin
            o_tile_data  <= i_pe_data;
            o_tile_valid <= 1'b1;
            state        <= OUTPUT;
          end
`ifdef CONV_SCHED_WATCHDOG_EN
          else if (wdt_cnt == WDT_W'(WDT_CYCLES - 1)) begin
            o_error       <= 1'b1;
            o_proc_finish <= 1'b1;
            o_busy        <= 1'b0;
            state         <= IDLE;
          end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
          end
`endif
        end
        OUTPUT: begin
          if (i_tile_accept) begin
            o_tile_valid  <= 1'b0;
            o_proc_finish <= 1'b1;
            if (pos_last) begin
              o_frame_done <= 1'b1;
              o_busy       <= 1'b0;
              state        <= IDLE;
            end else begin
              state <= WAIT_TILE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed scoreboard bench for conv_tile_scheduler (watchdog steps need CONV_SCHED_WATCHDOG_EN).
module tb_conv_tile_scheduler;

  localparam int SE       = 4 - 3 + 1;
  localparam int TCOLS    = (10 - 4) / SE + 1;
  localparam int TROWS    = (10 - 4) / SE + 1;
  localparam int NTILES   = TCOLS * TROWS;
  localparam int OUT_BITS = SE * SE * (8 + 8 + 13);

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                i_start = 1'b0;
  logic                i_tile_ready = 1'b0;
  logic                o_pe_valid;
  logic                i_pe_final_compute = 1'b0;
  logic                i_pe_final_flatten = 1'b0;
  logic [OUT_BITS-1:0] i_pe_data = '0;
  logic [OUT_BITS-1:0] o_tile_data;
  logic                o_tile_valid;
  logic                i_tile_accept = 1'b0;
  logic                o_proc_finish;
  logic [1:0]          o_tile_row;
  logic [1:0]          o_tile_col;
  logic                o_frame_done;
  logic                o_busy;
  logic                o_error;

  conv_tile_scheduler #(
    .INPUT_IMAGE_WIDTH  (10),
    .INPUT_IMAGE_HEIGHT (10),
    .INPUT_TILE_SIZE    (4),
    .KERNEL_SIZE        (3),
    .INPUT_DATA_WIDTH   (8),
    .KERNEL_DATA_WIDTH  (8),
    .WDT_CYCLES         (16)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .i_start            (i_start),
    .i_tile_ready       (i_tile_ready),
    .o_pe_valid         (o_pe_valid),
    .i_pe_final_compute (i_pe_final_compute),
    .i_pe_final_flatten (i_pe_final_flatten),
    .i_pe_data          (i_pe_data),
    .o_tile_data        (o_tile_data),
    .o_tile_valid       (o_tile_valid),
    .i_tile_accept      (i_tile_accept),
    .o_proc_finish      (o_proc_finish),
    .o_tile_row         (o_tile_row),
    .o_tile_col         (o_tile_col),
    .o_frame_done       (o_frame_done),
    .o_busy             (o_busy),
    .o_error            (o_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_launch = 0;
  int n_finish = 0;
  int n_done   = 0;
  logic [OUT_BITS-1:0] exp_q[$];

  always @(negedge clk) begin
    if (o_pe_valid)    n_launch++;
    if (o_proc_finish) n_finish++;
    if (o_frame_done)  n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_data(output logic [OUT_BITS-1:0] d);
    d = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pe_valid"}, o_pe_valid, 0);
    check({tag, "_tile_valid"}, o_tile_valid, 0);
    check({tag, "_tile_data"}, o_tile_data, 0);
    check({tag, "_proc_finish"}, o_proc_finish, 0);
    check({tag, "_row"}, o_tile_row, 0);
    check({tag, "_col"}, o_tile_col, 0);
    check({tag, "_frame_done"}, o_frame_done, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_error"}, o_error, 0);
  endtask

  // Ready in cycle t; launch strobe expected only in cycle t+2.
  task automatic launch_tile(input int row, input int col);
    check("pos_row", o_tile_row, row);
    check("pos_col", o_tile_col, col);
    i_tile_ready = 1'b1;
    tick();
    i_tile_ready = 1'b0;
    check("pe_valid_t1", o_pe_valid, 0);
    tick();
    check("pe_valid_t2", o_pe_valid, 1);
    tick();
    check("pe_valid_t3", o_pe_valid, 0);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !o_tile_valid; i++) tick();
    check("tile_valid_arrives", o_tile_valid, 1);
  endtask

  // mode 0: accept at once, 1: 10-cycle backpressure, 2: start/ready pulsed in OUTPUT.
  task automatic finish_tile(input bit last, input int nrow, input int ncol, input int mode);
    logic [OUT_BITS-1:0] d;
    logic [OUT_BITS-1:0] held;
    logic [1:0] r0, c0;
    rand_data(d);
    i_pe_data = d;
    i_pe_final_compute = 1'b1;
    i_pe_final_flatten = 1'b1;
    exp_q.push_back(d);
    tick();
    i_pe_final_compute = 1'b0;
    i_pe_final_flatten = 1'b0;
    wait_valid();
    held = exp_q.pop_front();
    check("tile_data", o_tile_data, held);
    r0 = o_tile_row;
    c0 = o_tile_col;
    if (mode == 1) begin
      for (int i = 0; i < 10; i++) begin
        rand_data(d);
        i_pe_data = d;
        tick();
        check("bp_data_stable", o_tile_data, held);
        check("bp_valid_stable", o_tile_valid, 1);
        check("bp_no_finish", o_proc_finish, 0);
      end
    end else if (mode == 2) begin
      i_start = 1'b1;
      i_tile_ready = 1'b1;
      tick();
      i_start = 1'b0;
      i_tile_ready = 1'b0;
      tick();
      check("spur_no_launch_a", o_pe_valid, 0);
      tick();
      check("spur_no_launch_b", o_pe_valid, 0);
      check("spur_row", o_tile_row, r0);
      check("spur_col", o_tile_col, c0);
      check("spur_valid", o_tile_valid, 1);
    end
    i_tile_accept = 1'b1;
    tick();
    i_tile_accept = 1'b0;
    check("acc_valid_low", o_tile_valid, 0);
    check("acc_finish", o_proc_finish, 1);
    check("acc_frame_done", o_frame_done, last);
    check("acc_row", o_tile_row, nrow);
    check("acc_col", o_tile_col, ncol);
    check("acc_busy", o_busy, !last);
    tick();
    check("finish_one_cycle", o_proc_finish, 0);
    check("frame_done_one_cycle", o_frame_done, 0);
  endtask

  initial begin
    int l0, f0, d0;
    logic [OUT_BITS-1:0] bogus;

    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    check("idle_busy", o_busy, 0);

    // Full frame with backpressure, flatten-without-compute and spurious inputs mixed in.
    l0 = n_launch; f0 = n_finish; d0 = n_done;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("start_busy", o_busy, 1);
    for (int i = 0; i < NTILES; i++) begin
      launch_tile(i / TCOLS, i % TCOLS);
      if (i == 2) begin
        rand_data(bogus);
        i_pe_data = bogus;
        i_pe_final_flatten = 1'b1;
        tick();
        i_pe_final_flatten = 1'b0;
        check("flatten_wo_compute", o_tile_valid, 0);
        tick();
        check("flatten_wo_compute_b", o_tile_valid, 0);
      end else begin
        tick();
        tick();
      end
      finish_tile(i == NTILES - 1, ((i + 1) % NTILES) / TCOLS, ((i + 1) % NTILES) % TCOLS,
                  (i == 1) ? 1 : ((i == 3) ? 2 : 0));
    end
    check("frame_launches", n_launch - l0, NTILES);
    check("frame_finishes", n_finish - f0, NTILES);
    check("frame_done_count", n_done - d0, 1);
    check("frame_end_busy", o_busy, 0);

    // Reset during COMPUTE of the fifth tile.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      launch_tile(i / TCOLS, i % TCOLS);
      tick();
      finish_tile(1'b0, (i + 1) / TCOLS, (i + 1) % TCOLS, 0);
    end
    launch_tile(1, 0);
    f0 = n_finish;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("midreset");
    tick();
    check("midreset_no_finish", n_finish - f0, 0);
    i_tile_ready = 1'b1;
    tick();
    tick();
    i_tile_ready = 1'b0;
    check("midreset_idle_no_launch", o_pe_valid, 0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("restart_busy", o_busy, 1);
    launch_tile(0, 0);
    tick();
    finish_tile(1'b0, 0, 1, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

`ifdef CONV_SCHED_WATCHDOG_EN
    begin
      int waited;
      f0 = n_finish;
      d0 = n_done;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      launch_tile(0, 0);
      waited = 0;
      for (int i = 0; i < 40 && !o_error; i++) begin
        tick();
        waited++;
      end
      check("wdt_error", o_error, 1);
      check("wdt_finish", o_proc_finish, 1);
      check("wdt_busy", o_busy, 0);
      check("wdt_latency_ok", (waited >= 12 && waited <= 20), 1);
      tick();
      check("wdt_error_sticky", o_error, 1);
      check("wdt_finish_count", n_finish - f0, 1);
      check("wdt_no_frame_done", n_done - d0, 0);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("wdt_start_clears", o_error, 0);
      check("wdt_restart_busy", o_busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
    end
`else
    check("no_wdt_error", o_error, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
